// File: rtl/turn_signal_conditioner.sv
// Input conditioner for the tail-light sequencer: synchronises, debounces and
// decodes the raw dashboard switches into mutually exclusive InL/InR/InH levels.
module turn_signal_conditioner #(
    parameter int TICK_DIV        = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset_b,
    input  logic sw_left,
    input  logic sw_right,
    input  logic sw_hazard,
    output logic InL,
    output logic InR,
    output logic InH
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel order in every 3-bit vector: [0]=left, [1]=right, [2]=hazard.
    logic [2:0]        raw;
    logic [2:0]        sync_p0;
    logic [2:0]        sync_p1;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [2:0]        deb;
    logic [2:0]        deb_next;
    logic [CNT_W-1:0]  cnt      [3];
    logic [CNT_W-1:0]  cnt_next [3];
    logic [2:0]        req_next;

    assign raw = {sw_hazard, sw_right, sw_left};

    // Priority decode; left+right together is promoted to hazard so the
    // sequencer never sees conflicting requests. Result is {H, R, L}.
    function automatic logic [2:0] decode(input logic [2:0] d);
        logic [2:0] r;
        r = 3'b000;
        if (d[2] || (d[0] && d[1])) begin
            r = 3'b100;
        end else if (d[0]) begin
            r = 3'b001;
        end else if (d[1]) begin
            r = 3'b010;
        end
        return r;
    endfunction

    // Stage p0/p1: two-flop synchroniser per channel
    always_ff @(posedge clock or posedge reset_b) begin
        if (reset_b) begin
            sync_p0 <= 3'b000;
            sync_p1 <= 3'b000;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clock or posedge reset_b) begin
        if (reset_b) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Any agreeing tick restarts qualification, so only an unbroken run of
    // DEBOUNCE_CYCLES disagreeing ticks moves the stable level.
    always_comb begin
        deb_next = deb;
        cnt_next = cnt;
        if (tick) begin
            for (int i = 0; i < 3; i++) begin
                if (sync_p1[i] == deb[i]) begin
                    cnt_next[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb_next[i] = sync_p1[i];
                    cnt_next[i] = '0;
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Stage p2: debounced levels and qualification counters
    always_ff @(posedge clock or posedge reset_b) begin
        if (reset_b) begin
            deb <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb <= deb_next;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign req_next = decode(deb);

    // Stage p3: registered one-hot request levels
    always_ff @(posedge clock or posedge reset_b) begin
        if (reset_b) begin
            InL <= 1'b0;
            InR <= 1'b0;
            InH <= 1'b0;
        end else begin
            InL <= req_next[0];
            InR <= req_next[1];
            InH <= req_next[2];
        end
    end

endmodule

// File: tb/tb_turn_signal_conditioner.sv
// Self-checking bench for turn_signal_conditioner: directed scenarios with
// literal edge expectations plus randomized bouncing against a behavioural model.
module tb_turn_signal_conditioner;

    localparam int TD = 8;
    localparam int DC = 4;

    logic clock;
    logic reset_b;
    logic sw_left;
    logic sw_right;
    logic sw_hazard;
    logic InL;
    logic InR;
    logic InH;

    int errors = 0;
    int checks = 0;

    // Behavioural model: raw history, consecutive-disagreement runs, levels.
    int       edge_n;
    bit       mdeb [3];
    int       run  [3];
    bit       p1   [3];
    bit       p2   [3];
    bit [2:0] mout;

    turn_signal_conditioner #(
        .TICK_DIV        (TD),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clock     (clock),
        .reset_b   (reset_b),
        .sw_left   (sw_left),
        .sw_right  (sw_right),
        .sw_hazard (sw_hazard),
        .InL       (InL),
        .InR       (InR),
        .InH       (InH)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        assert ($onehot0({InL, InR, InH}))
            else $error("FAIL onehot0 outputs InL=%0b InR=%0b InH=%0b", InL, InR, InH);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at model edge %0d: got %b, expected %b", name, edge_n, act, req);
        end
    endtask

    function automatic bit [2:0] want(input bit l, input bit r, input bit h);
        if (h || (l && r)) return 3'b100;
        if (l) return 3'b001;
        if (r) return 3'b010;
        return 3'b000;
    endfunction

    task automatic model_reset();
        edge_n = 0;
        mout   = 3'b000;
        for (int i = 0; i < 3; i++) begin
            mdeb[i] = 1'b0;
            run[i]  = 0;
            p1[i]   = 1'b0;
            p2[i]   = 1'b0;
        end
    endtask

    task automatic model_edge(input bit l, input bit r, input bit h);
        bit       cur [3];
        bit [2:0] nxt;
        cur = '{l, r, h};
        edge_n++;
        nxt = want(mdeb[0], mdeb[1], mdeb[2]);
        if (edge_n % TD == 0) begin
            // p2 holds the raw value seen two edges earlier
            for (int i = 0; i < 3; i++) begin
                if (p2[i] == mdeb[i]) begin
                    run[i] = 0;
                end else begin
                    run[i]++;
                    if (run[i] == DC) begin
                        mdeb[i] = p2[i];
                        run[i]  = 0;
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            p2[i] = p1[i];
            p1[i] = cur[i];
        end
        mout = nxt;
    endtask

    // One clock cycle: drive inputs after the falling edge, update the model on
    // the rising edge, compare on the next falling edge.
    task automatic step(input bit l, input bit r, input bit h, input bit rst);
        sw_left   = l;
        sw_right  = r;
        sw_hazard = h;
        reset_b   = rst;
        if (rst) begin
            model_reset();
            #1;
            check("reset_outputs", {InH, InR, InL}, 3'b000);
        end
        @(posedge clock);
        if (!rst) model_edge(l, r, h);
        @(negedge clock);
        check("model", {InH, InR, InL}, mout);
    endtask

    initial begin
        int  rise;
        int  fall;
        bit  seen_bad;
        bit  tgt [3];
        bit  v   [3];
        bit  rr;

        reset_b   = 1'b1;
        sw_left   = 1'b0;
        sw_right  = 1'b0;
        sw_hazard = 1'b0;
        model_reset();

        // Left held from reset release, then released at edge 41.
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        rise = -1;
        seen_bad = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            step(1, 0, 0, 0);
            if (InL === 1'b1 && rise < 0) rise = edge_n;
            if (InR !== 1'b0 || InH !== 1'b0) seen_bad = 1'b1;
        end
        check("left_rise_edge", 3'(rise == 33), 3'd1);
        check("left_only", {2'b00, seen_bad}, 3'b000);
        check("left_held", {InH, InR, InL}, 3'b001);
        fall = -1;
        for (int n = 0; n < 80 && fall < 0; n++) begin
            step(0, 0, 0, 0);
            if (InL === 1'b0) fall = edge_n;
        end
        check("left_fall_edge", 3'(fall == 73), 3'd1);

        // Right toggling every 3 cycles never qualifies.
        step(0, 0, 0, 1);
        seen_bad = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step(0, bit'((c / 3) % 2), 0, 0);
            if (InR !== 1'b0) seen_bad = 1'b1;
        end
        for (int c = 0; c < 60; c++) begin
            step(0, 0, 0, 0);
            if (InR !== 1'b0) seen_bad = 1'b1;
        end
        check("right_bounce_quiet", {2'b00, seen_bad}, 3'b000);

        // Left and right together promote to hazard.
        step(0, 0, 0, 1);
        rise = -1;
        seen_bad = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            step(1, 1, 0, 0);
            if (InH === 1'b1 && rise < 0) rise = edge_n;
            if (InL !== 1'b0 || InR !== 1'b0) seen_bad = 1'b1;
        end
        check("lr_hazard_rise_edge", 3'(rise == 33), 3'd1);
        check("lr_no_left_right", {2'b00, seen_bad}, 3'b000);

        // Hazard held, reset pulsed over edge 50, must requalify from scratch.
        step(0, 0, 1, 1);
        for (int n = 1; n <= 49; n++) step(0, 0, 1, 0);
        check("hazard_before_reset", {InH, InR, InL}, 3'b100);
        step(0, 0, 1, 1);
        rise = -1;
        for (int n = 1; n <= 50; n++) begin
            step(0, 0, 1, 0);
            if (InH === 1'b1 && rise < 0) rise = edge_n;
        end
        check("hazard_rerise_edge", 3'(rise == 33), 3'd1);

        // Random bouncing with slowly moving targets and occasional resets.
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) tgt[i] = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 59) == 0) tgt[i] = ~tgt[i];
                v[i] = tgt[i] ^ ($urandom_range(0, 9) == 0);
            end
            rr = ($urandom_range(0, 2999) == 0);
            step(v[0], v[1], v[2], rr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
